// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arms the delay line, counts coarse cycles to the hit,
// samples the settled fine code and hands out one {coarse, fine} timestamp via valid/ready.
module tdc_meas_ctrl #(
  parameter int COARSE_W = 16,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hit,
  input  logic [7:0]          fine,
  output logic                arm,
  output logic                busy,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [7:0]          ts_fine,
  output logic                ts_timeout,
  output logic                start_drop
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETTLE,
    ST_OUT
  } state_t;

  localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'(TIMEOUT - 1);
  localparam logic [COARSE_W-1:0] COARSE_ONE  = COARSE_W'(1);
  localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE - 1);

  state_t                state_reg, state_next;
  logic [COARSE_W-1:0]   coarse_reg, coarse_next;
  logic [3:0]            settle_reg, settle_next;
  logic [COARSE_W-1:0]   ts_coarse_reg, ts_coarse_next;
  logic [7:0]            ts_fine_reg, ts_fine_next;
  logic                  ts_timeout_reg, ts_timeout_next;
  logic                  arm_reg, busy_reg, ts_valid_reg, start_drop_reg;

  always_comb begin
    state_next      = state_reg;
    coarse_next     = coarse_reg;
    settle_next     = settle_reg;
    ts_coarse_next  = ts_coarse_reg;
    ts_fine_next    = ts_fine_reg;
    ts_timeout_next = ts_timeout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_ARMED;
          coarse_next = '0;
        end
      end
      ST_ARMED: begin
        // A hit on the last armed cycle still counts as a normal capture.
        if (hit) begin
          state_next     = ST_SETTLE;
          ts_coarse_next = coarse_reg;
          settle_next    = '0;
        end else if (coarse_reg == COARSE_LAST) begin
          state_next      = ST_OUT;
          ts_coarse_next  = coarse_reg;
          ts_fine_next    = '0;
          ts_timeout_next = 1'b1;
        end else begin
          coarse_next = coarse_reg + COARSE_ONE;
        end
      end
      ST_SETTLE: begin
        settle_next = settle_reg + 4'd1;
        if (settle_reg == SETTLE_LAST) begin
          state_next      = ST_OUT;
          ts_fine_next    = fine;
          ts_timeout_next = 1'b0;
        end
      end
      ST_OUT: begin
        if (ts_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      coarse_reg     <= '0;
      settle_reg     <= '0;
      ts_coarse_reg  <= '0;
      ts_fine_reg    <= '0;
      ts_timeout_reg <= 1'b0;
      arm_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      ts_valid_reg   <= 1'b0;
      start_drop_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      coarse_reg     <= coarse_next;
      settle_reg     <= settle_next;
      ts_coarse_reg  <= ts_coarse_next;
      ts_fine_reg    <= ts_fine_next;
      ts_timeout_reg <= ts_timeout_next;
      arm_reg        <= (state_next == ST_ARMED);
      busy_reg       <= (state_next != ST_IDLE);
      ts_valid_reg   <= (state_next == ST_OUT);
      start_drop_reg <= start && (state_reg != ST_IDLE);
    end
  end

  assign arm        = arm_reg;
  assign busy       = busy_reg;
  assign ts_valid   = ts_valid_reg;
  assign ts_coarse  = ts_coarse_reg;
  assign ts_fine    = ts_fine_reg;
  assign ts_timeout = ts_timeout_reg;
  assign start_drop = start_drop_reg;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: capture, timeout, late hit, back-pressure,
// mid-measurement reset and back-to-back starts.
module tb_tdc_meas_ctrl;

  localparam int COARSE_W = 16;
  localparam int SETTLE   = 2;
  localparam int TIMEOUT  = 1000;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                hit;
  logic [7:0]          fine;
  logic                arm;
  logic                busy;
  logic                ts_valid;
  logic                ts_ready;
  logic [COARSE_W-1:0] ts_coarse;
  logic [7:0]          ts_fine;
  logic                ts_timeout;
  logic                start_drop;

  int n_cmp = 0;
  int n_err = 0;

  tdc_meas_ctrl #(
    .COARSE_W(COARSE_W),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .fine      (fine),
    .arm       (arm),
    .busy      (busy),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_coarse (ts_coarse),
    .ts_fine   (ts_fine),
    .ts_timeout(ts_timeout),
    .start_drop(start_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic a, input logic b, input logic v);
    check_val({tag, ".arm"}, 32'(arm), 32'(a));
    check_val({tag, ".busy"}, 32'(busy), 32'(b));
    check_val({tag, ".valid"}, 32'(ts_valid), 32'(v));
  endtask

  task automatic check_rec(input string tag, input int c, input logic [7:0] f, input logic to);
    check_val({tag, ".valid"}, 32'(ts_valid), 32'd1);
    check_val({tag, ".coarse"}, 32'(ts_coarse), 32'(c));
    check_val({tag, ".fine"}, 32'(ts_fine), 32'(f));
    check_val({tag, ".timeout"}, 32'(ts_timeout), 32'(to));
  endtask

  // Start sampled on the next edge; the DUT is ARMED with count 0 afterwards.
  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_status({tag, ".armed"}, 1'b1, 1'b1, 1'b0);
  endtask

  // Hit at coarse count c with fine code f, then wait out the settle window.
  task automatic do_hit(input string tag, input int c, input logic [7:0] f);
    repeat (c) tick();
    hit  = 1'b1;
    fine = f;
    tick();
    hit = 1'b0;
    check_status({tag, ".settle"}, 1'b0, 1'b1, 1'b0);
    repeat (SETTLE) tick();
  endtask

  task automatic do_transfer(input string tag);
    $display("xfer %s: coarse=%0d fine=%02h timeout=%0d", tag, ts_coarse, ts_fine, ts_timeout);
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    check_status({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int drops;
    logic [COARSE_W-1:0] hold_c;
    logic [7:0] hold_f;
    logic hold_t;

    rst = 1'b1; start = 1'b0; hit = 1'b0; fine = 8'h00; ts_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_status("reset", 1'b0, 1'b0, 1'b0);
    check_val("reset.coarse", 32'(ts_coarse), 32'd0);
    check_val("reset.fine", 32'(ts_fine), 32'd0);
    check_val("reset.timeout", 32'(ts_timeout), 32'd0);
    check_val("reset.drop", 32'(start_drop), 32'd0);

    // Basic capture: hit at count 4, fine A7
    do_start("cap");
    do_hit("cap", 4, 8'hA7);
    check_rec("cap", 4, 8'hA7, 1'b0);
    do_transfer("cap");

    // Timeout: arm high for exactly TIMEOUT cycles
    fine = 8'h55;
    do_start("tmo");
    n = 1;
    while (arm && n < 2000) begin
      tick();
      if (arm) n++;
    end
    check_val("tmo.arm_cycles", 32'(n), 32'(TIMEOUT));
    check_rec("tmo", TIMEOUT - 1, 8'h00, 1'b1);
    do_transfer("tmo");

    // Hit on the timeout cycle wins
    do_start("late");
    do_hit("late", TIMEOUT - 1, 8'h3C);
    check_rec("late", TIMEOUT - 1, 8'h3C, 1'b0);
    do_transfer("late");

    // Back-pressure: record held, every start dropped
    do_start("bp");
    do_hit("bp", 7, 8'h81);
    check_rec("bp", 7, 8'h81, 1'b0);
    hold_c = ts_coarse; hold_f = ts_fine; hold_t = ts_timeout;
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      fine  = 8'($urandom);
      start = (i % 7 == 3);
      tick();
      check_val("bp.drop", 32'(start_drop), 32'(start));
      if (start_drop) drops++;
      start = 1'b0;
      check_val("bp.hold", {hold_t, hold_f, 7'd0, hold_c}, {ts_timeout, ts_fine, 7'd0, ts_coarse});
      check_val("bp.valid", 32'(ts_valid), 32'd1);
    end
    tick();
    check_val("bp.drop_last", 32'(start_drop), 32'd0);
    check_val("bp.drop_count", 32'(drops), 32'd7);
    do_transfer("bp");
    tick();
    check_val("bp.single_xfer", 32'(ts_valid), 32'd0);

    // Reset during ARMED
    do_start("rsta");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_status("rsta", 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check_status("rsta.quiet", 1'b0, 1'b0, 1'b0);

    // Reset during SETTLE
    do_start("rsts");
    hit = 1'b1;
    tick();
    hit = 1'b0;
    check_status("rsts.settle", 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_status("rsts", 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check_status("rsts.quiet", 1'b0, 1'b0, 1'b0);

    // Fresh measurement after resets
    do_start("fresh");
    do_hit("fresh", 2, 8'h11);
    check_rec("fresh", 2, 8'h11, 1'b0);

    // Start on the transfer cycle is dropped
    start    = 1'b1;
    ts_ready = 1'b1;
    tick();
    start    = 1'b0;
    ts_ready = 1'b0;
    check_status("b2b.xfer", 1'b0, 1'b0, 1'b0);
    check_val("b2b.xfer_drop", 32'(start_drop), 32'd1);
    tick();
    check_status("b2b.not_accepted", 1'b0, 1'b0, 1'b0);
    check_val("b2b.drop_clear", 32'(start_drop), 32'd0);

    // Start the cycle after transfer is accepted
    do_start("b2b1");
    do_hit("b2b1", 1, 8'hC3);
    check_rec("b2b1", 1, 8'hC3, 1'b0);
    do_transfer("b2b1");
    do_start("b2b2");
    check_val("b2b2.drop", 32'(start_drop), 32'd0);
    do_hit("b2b2", 0, 8'h5A);
    check_rec("b2b2", 0, 8'h5A, 1'b0);
    do_transfer("b2b2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC front end. It arms the tapped delay line and counts coarse clock cycles until the stop edge is flagged. It then waits for the thermometer-to-binary converter output to settle, samples the 8-bit fine code, and presents one {coarse, fine} timestamp through a valid/ready handshake. It sits between the host/trigger logic and the delay-line + `unary2binary` conversion path, and is the only block that drives the delay-line enable.

## Interface
Parameters:
- `COARSE_W`, 16: coarse counter width.
- `SETTLE`, 2: cycles from hit to fine-code sample. Legal range 1..15.
- `TIMEOUT`, 1000: maximum armed cycles before abort. Legal range 2..2^COARSE_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one measurement; accepted only in IDLE.
- `hit` in 1: delay-line sampler reports that the stop edge was captured this cycle.
- `fine` in 8: binary fine code from the converter.
- `arm` out 1: delay-line enable.
- `busy` out 1: high in every state except IDLE.
- `ts_valid` out 1: timestamp available.
- `ts_ready` in 1: consumer accepts the timestamp.
- `ts_coarse` out COARSE_W: coarse count at the hit.
- `ts_fine` out 8: sampled fine code.
- `ts_timeout` out 1: this timestamp is a timeout record.
- `start_drop` out 1: one-cycle pulse when `start` is ignored.

## Operation
FSM states: IDLE, ARMED, SETTLE, OUT.
- IDLE:
  - `arm`=0, `busy`=0.
  - `start`=1 → ARMED; coarse counter loads 0.
  - `hit` is ignored.
- ARMED:
  - `arm`=1; coarse counter increments by 1 per cycle.
  - `hit`=1 → SETTLE; `ts_coarse` latches the current count; settle counter loads 0.
  - No hit and count == TIMEOUT-1 → OUT with `ts_timeout`=1, `ts_coarse`=TIMEOUT-1, `ts_fine`=0.
  - Hit on the timeout cycle: the hit wins, and the cycle is treated as a normal capture.
- SETTLE:
  - `arm`=0.
  - Settle counter increments each cycle.
  - On the cycle where the counter == SETTLE-1: `ts_fine` ← `fine`, `ts_timeout` ← 0, go to OUT.
  - `hit` is ignored.
- OUT:
  - `ts_valid`=1.
  - `ts_coarse`, `ts_fine` and `ts_timeout` are held stable until the transfer.
  - Transfer happens when `ts_valid`&&`ts_ready`; the next state is IDLE.
  - Back-pressure is unbounded; there is no loss.
- `start`=1 in any state other than IDLE, including the transfer cycle, is dropped: `start_drop`=1 on the following cycle. No queueing.
- The coarse counter never wraps, because TIMEOUT ≤ 2^COARSE_W.

## Timing
- Reset value of every output is 0; state is IDLE.
- Reset asserted in any state aborts the measurement in the next cycle: no `ts_valid`, `arm`=0.
- `start` sampled at cycle S → `arm`/`busy` high from S+1. The first ARMED cycle has coarse count 0.
- `hit` sampled at ARMED cycle H, where the coarse count at H is c → `ts_coarse`=c.
  - `arm` low from H+1.
  - `fine` sampled at edge H+SETTLE.
  - `ts_valid` high from H+SETTLE+1.
- Timeout: `ts_valid` high from S+TIMEOUT+1 (TIMEOUT armed cycles).
- Transfer at cycle T → IDLE at T+1; `ts_valid`/`busy` low at T+1. The earliest new `start` is accepted at T+1, with ARMED at T+2.
- `ts_valid` never depends combinationally on `ts_ready`. All outputs are registered.

## Test plan
- Reset, then `start` at cycle 10, `hit` at cycle 15, `fine`=8'hA7 steady, `ts_ready`=1 → `ts_valid` at cycle 18 (SETTLE=2) with `ts_coarse`=4, `ts_fine`=8'hA7, `ts_timeout`=0; IDLE at cycle 19.
- `start` with no `hit`, TIMEOUT=1000 → `arm` high for exactly 1000 cycles; `ts_valid` with `ts_timeout`=1, `ts_coarse`=999, `ts_fine`=0.
- `hit` on the timeout cycle (count 999), `fine`=8'h3C → normal record with `ts_coarse`=999, `ts_fine`=8'h3C, `ts_timeout`=0.
- Hold `ts_ready`=0 for 50 cycles in OUT while `fine` changes and `start` pulses → outputs stay constant; `start_drop` pulses once per `start`; one transfer when `ts_ready`=1.
- `rst` pulsed during ARMED and again during SETTLE → `arm`/`busy` low the next cycle, no `ts_valid`; a fresh `start` then measures correctly.
- Back-to-back: `start` on the cycle after the transfer → accepted, `arm` high 2 cycles after the transfer; `start` on the transfer cycle itself → `start_drop`=1, not accepted.
